// File: rtl/echo_feedforward.sv
// Feedforward echo stage: y[n] = sat((dry*x[n] + wet*x[n-D]) / 2^(COEF_W-1)).
// Block-RAM delay line with run-time delay/gains, fixed 3-cycle latency.
module echo_feedforward #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 2048,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int COEF_W = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] audio_in,
  input  logic [ADDR_W-1:0] delay,
  input  logic [COEF_W-1:0] dry_gain,
  input  logic [COEF_W-1:0] wet_gain,
  output logic              out_valid,
  output logic [DATA_W-1:0] audio_out
);

  localparam int PROD_W = DATA_W + COEF_W + 1;
  localparam int SUM_W  = PROD_W + 1;

  localparam logic [ADDR_W-1:0]       PTR_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W:0]         FILL_ONE = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0]         FILL_MAX = (ADDR_W+1)'(DEPTH);
  localparam logic signed [SUM_W-1:0] ROUND    = {{(SUM_W-COEF_W+1){1'b0}}, 1'b1, {(COEF_W-2){1'b0}}};
  localparam logic signed [SUM_W-1:0] SAT_MAX  = {{(SUM_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] SAT_MIN  = {{(SUM_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rd_data;
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W:0]   r_fill;

  logic [ADDR_W-1:0] w_ptr;
  logic [ADDR_W:0]   w_fill;
  logic [ADDR_W-1:0] w_rd_addr;

  logic              r1_valid;
  logic [DATA_W-1:0] r1_x;
  logic              r1_zero;
  logic              r1_dz;
  logic [COEF_W-1:0] r1_dry;
  logic [COEF_W-1:0] r1_wet;

  logic [DATA_W-1:0]        w_d;
  logic signed [PROD_W-1:0] w_p_dry;
  logic signed [PROD_W-1:0] w_p_wet;

  logic                     r2_valid;
  logic signed [PROD_W-1:0] r2_p_dry;
  logic signed [PROD_W-1:0] r2_p_wet;

  logic signed [SUM_W-1:0]  w_sum;
  logic signed [SUM_W-1:0]  w_shift;
  logic [DATA_W-1:0]        w_sat;

  // A flush in the same cycle as a sample makes that sample land at address 0 with empty history.
  always_comb begin
    w_ptr     = flush ? {ADDR_W{1'b0}} : r_wr_ptr;
    w_fill    = flush ? {(ADDR_W+1){1'b0}} : r_fill;
    w_rd_addr = w_ptr - delay;
  end

  // Delay-line RAM: write current sample, synchronous read of the delayed one.
  always_ff @(posedge clk) begin
    if (in_valid) begin
      r_mem[w_ptr] <= audio_in;
      r_rd_data    <= r_mem[w_rd_addr];
    end
  end

  // Write pointer and saturating fill count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= {ADDR_W{1'b0}};
      r_fill   <= {(ADDR_W+1){1'b0}};
    end else if (in_valid) begin
      r_wr_ptr <= w_ptr + PTR_ONE;
      r_fill   <= (w_fill == FILL_MAX) ? w_fill : w_fill + FILL_ONE;
    end else if (flush) begin
      r_wr_ptr <= {ADDR_W{1'b0}};
      r_fill   <= {(ADDR_W+1){1'b0}};
    end
  end

  // S1: capture sample, gains and history flags alongside the RAM read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r1_valid <= 1'b0;
      r1_x     <= {DATA_W{1'b0}};
      r1_zero  <= 1'b0;
      r1_dz    <= 1'b0;
      r1_dry   <= {COEF_W{1'b0}};
      r1_wet   <= {COEF_W{1'b0}};
    end else begin
      r1_valid <= in_valid;
      if (in_valid) begin
        r1_x    <= audio_in;
        r1_zero <= (w_fill < {1'b0, delay});
        r1_dz   <= (delay == {ADDR_W{1'b0}});
        r1_dry  <= dry_gain;
        r1_wet  <= wet_gain;
      end
    end
  end

  // Zero delay bypasses the RAM so no read-during-write ordering is needed.
  always_comb begin
    if (r1_dz) begin
      w_d = r1_x;
    end else if (r1_zero) begin
      w_d = {DATA_W{1'b0}};
    end else begin
      w_d = r_rd_data;
    end
    w_p_dry = PROD_W'($signed(r1_x)) * PROD_W'($signed({1'b0, r1_dry}));
    w_p_wet = PROD_W'($signed(w_d))  * PROD_W'($signed({1'b0, r1_wet}));
  end

  // S2: product registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r2_valid <= 1'b0;
      r2_p_dry <= {PROD_W{1'b0}};
      r2_p_wet <= {PROD_W{1'b0}};
    end else begin
      r2_valid <= r1_valid;
      if (r1_valid) begin
        r2_p_dry <= w_p_dry;
        r2_p_wet <= w_p_wet;
      end
    end
  end

  // Round half up, rescale from Q1.(COEF_W-1), then clamp to the sample range.
  always_comb begin
    w_sum   = SUM_W'(r2_p_dry) + SUM_W'(r2_p_wet) + ROUND;
    w_shift = w_sum >>> (COEF_W - 1);
    if (w_shift > SAT_MAX) begin
      w_sat = SAT_MAX[DATA_W-1:0];
    end else if (w_shift < SAT_MIN) begin
      w_sat = SAT_MIN[DATA_W-1:0];
    end else begin
      w_sat = w_shift[DATA_W-1:0];
    end
  end

  // S3: output register, held between valid pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      audio_out <= {DATA_W{1'b0}};
    end else begin
      out_valid <= r2_valid;
      if (r2_valid) begin
        audio_out <= w_sat;
      end
    end
  end

endmodule

// File: tb/tb_echo_feedforward.sv
// Scoreboard bench for echo_feedforward (DEPTH=16 build): driver queues expected
// outputs with issue cycle, a negedge monitor checks value, latency and hold.
module tb_echo_feedforward;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] audio_in = 16'd0;
  logic [3:0]  delay = 4'd0;
  logic [8:0]  dry_gain = 9'd0;
  logic [8:0]  wet_gain = 9'd0;
  logic        out_valid;
  logic [15:0] audio_out;

  echo_feedforward #(
    .DATA_W(16), .DEPTH(16), .ADDR_W(4), .COEF_W(9)
  ) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
    .audio_in(audio_in), .delay(delay), .dry_gain(dry_gain), .wet_gain(wet_gain),
    .out_valid(out_valid), .audio_out(audio_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int val; int t; } exp_t;
  exp_t sb[$];

  int errors = 0;
  int checks = 0;
  logic done = 1'b0;
  logic final_done = 1'b0;
  logic [15:0] last_out = 16'd0;

  int cur_d = 0;
  int cur_dry = 0;
  int cur_wet = 0;

  // Monitor: reset state, scoreboard compare with latency, hold between pulses.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      checks++;
      if (out_valid !== 1'b0 || audio_out !== 16'd0) begin
        errors++;
        $display("FAIL reset_state: out_valid=%0b audio_out=%0d, required 0 and 0", out_valid, $signed(audio_out));
      end
      last_out = 16'd0;
    end else if (out_valid) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output: audio_out=%0d with no pending sample", $signed(audio_out));
      end else begin
        e = sb.pop_front();
        if ($signed(audio_out) != e.val || (cyc - e.t) != 3) begin
          errors++;
          $display("FAIL sample_out: got %0d after %0d cycles, required %0d after 3 cycles",
                   $signed(audio_out), cyc - e.t, e.val);
        end
      end
      last_out = audio_out;
    end else begin
      checks++;
      if (audio_out !== last_out) begin
        errors++;
        $display("FAIL hold_out: audio_out=%0d changed without out_valid, required %0d",
                 $signed(audio_out), $signed(last_out));
      end
    end
    if (done && !final_done) begin
      final_done = 1'b1;
      checks++;
      if (sb.size() != 0) begin
        errors++;
        $display("FAIL missing_outputs: %0d samples never produced output, required 0", sb.size());
      end
    end
  end

  task automatic drive(input logic v, input logic fl, input int x, input int exp);
    @(posedge clk);
    #1;
    in_valid = v;
    flush    = fl;
    audio_in = 16'(x);
    delay    = 4'(cur_d);
    dry_gain = 9'(cur_dry);
    wet_gain = 9'(cur_wet);
    if (v) sb.push_back('{val: exp, t: cyc});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 0, 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // impulse: dry 1.0, wet 0.5, D=4
    cur_d = 4; cur_dry = 256; cur_wet = 128;
    drive(1'b1, 1'b0, 1000, 1000);
    for (int k = 2; k <= 8; k++) drive(1'b1, 1'b0, 0, (k == 5) ? 500 : 0);
    idle(4);

    // saturation both directions, D=1
    cur_d = 1; cur_dry = 256; cur_wet = 256;
    drive(1'b1, 1'b1, 30000, 30000);
    for (int k = 0; k < 4; k++) drive(1'b1, 1'b0, 30000, 32767);
    drive(1'b1, 1'b1, -30000, -30000);
    for (int k = 0; k < 4; k++) drive(1'b1, 1'b0, -30000, -32768);

    // D=0 uses the current sample as the delayed operand
    cur_d = 0;
    drive(1'b1, 1'b1, 1000, 2000);
    drive(1'b1, 1'b0, -7, -14);

    // rounding half up, plus gain above 1.0 clamping
    cur_dry = 128; cur_wet = 0;
    drive(1'b1, 1'b0, 3, 2);
    drive(1'b1, 1'b0, -3, -1);
    drive(1'b1, 1'b0, 1, 1);
    drive(1'b1, 1'b0, -1, 0);
    cur_dry = 511;
    drive(1'b1, 1'b0, 32767, 32767);
    idle(3);

    // max delay with pointer wrap: y[n] = x[n-15]
    cur_d = 15; cur_dry = 0; cur_wet = 256;
    for (int n = 1; n <= 40; n++) drive(1'b1, n == 1, n, (n > 15) ? n - 15 : 0);

    // flush mid-ramp at sample 9
    cur_d = 4; cur_dry = 256; cur_wet = 256;
    for (int n = 1; n <= 16; n++) begin
      automatic int base = (n < 9) ? 1 : 9;
      drive(1'b1, (n == 1) || (n == 9), n, (n - base >= 4) ? 2 * n - 4 : n);
    end

    // reset while samples are in flight
    for (int n = 1; n <= 6; n++) drive(1'b1, n == 1, 10 * n, (n > 4) ? 20 * n - 40 : 10 * n);
    #2;
    rst_n = 1'b0;
    in_valid = 1'b0;
    sb.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int n = 1; n <= 6; n++) drive(1'b1, 1'b0, 5 * n, (n > 4) ? 10 * n - 20 : 5 * n);
    idle(3);

    // gapped input; delay switches 2 -> 5 at sample 7
    cur_d = 2;
    for (int n = 1; n <= 10; n++) begin
      automatic int e;
      if (n == 7) cur_d = 5;
      if (n <= 2)      e = 10 * n;
      else if (n <= 6) e = 10 * n + 10 * (n - 2);
      else             e = 10 * n + 10 * (n - 5);
      drive(1'b1, n == 1, 10 * n, e);
      idle(2);
    end
    idle(6);

    done = 1'b1;
    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
